// File: rtl/sram_share_ctrl.sv
// Two-port arbiter and sequencer for a single-port synchronous SRAM,
// with a boot/command fill engine and tagged read-data return.
module sram_share_ctrl #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 10,
  parameter bit RR = 1'b1,
  parameter bit CLR_ON_RESET = 1'b1,
  parameter logic [DATA_WIDTH-1:0] CLR_VAL = '0
) (
  input  logic                  clk,
  input  logic                  RSTn,
  input  logic                  clr,
  output logic                  busy,
  input  logic                  reqA,
  input  logic                  reqB,
  input  logic                  weA,
  input  logic                  weB,
  input  logic [ADDR_WIDTH-1:0] addrA,
  input  logic [ADDR_WIDTH-1:0] addrB,
  input  logic [DATA_WIDTH-1:0] dinA,
  input  logic [DATA_WIDTH-1:0] dinB,
  output logic                  ackA,
  output logic                  ackB,
  output logic                  rvalidA,
  output logic                  rvalidB,
  output logic [DATA_WIDTH-1:0] rdata,
  output logic [ADDR_WIDTH-1:0] SRAM_ADDR,
  output logic [DATA_WIDTH-1:0] SRAM_DATA,
  output logic                  SRAM_CEn,
  output logic                  SRAM_OEn,
  output logic                  SRAM_WEn,
  input  logic [DATA_WIDTH-1:0] SRAM_Q
);

  typedef enum logic {CLEAR, RUN} state_t;

  localparam state_t RST_STATE =
    CLR_ON_RESET ? CLEAR : RUN;
  localparam logic [ADDR_WIDTH-1:0] LAST = '1;

  state_t state, state_nxt;
  logic [ADDR_WIDTH-1:0] cnt, cnt_nxt;
  logic last_b, last_b_nxt;
  logic [1:0] tag_v, tag_b;

  logic run_ok, pick_a, gnt_a, gnt_b, gnt;
  logic sel_we, rd_issue;
  logic [ADDR_WIDTH-1:0] sel_addr;
  logic [DATA_WIDTH-1:0] sel_din;

  // last_b=1 means B was granted most recently, so A wins a contest
  always_comb begin
    run_ok   = (state == RUN) && !clr;
    pick_a   = reqA && (!reqB || !RR || last_b);
    gnt_a    = run_ok && pick_a;
    gnt_b    = run_ok && reqB && !pick_a;
    gnt      = gnt_a || gnt_b;
    sel_we   = gnt_a ? weA : weB;
    sel_addr = gnt_a ? addrA : addrB;
    sel_din  = gnt_a ? dinA : dinB;
    rd_issue = gnt && !sel_we;
  end

  always_comb begin
    state_nxt  = state;
    cnt_nxt    = cnt;
    last_b_nxt = last_b;
    unique case (state)
      CLEAR: begin
        cnt_nxt = cnt + 1'b1;
        if (cnt == LAST) state_nxt = RUN;
      end
      RUN: begin
        if (clr) begin
          state_nxt = CLEAR;
          cnt_nxt   = '0;
        end
      end
    endcase
    if (gnt_a) last_b_nxt = 1'b0;
    if (gnt_b) last_b_nxt = 1'b1;
  end

  always_ff @(posedge clk or negedge RSTn) begin
    if (!RSTn) begin
      state  <= RST_STATE;
      cnt    <= '0;
      last_b <= 1'b1;
    end else begin
      state  <= state_nxt;
      cnt    <= cnt_nxt;
      last_b <= last_b_nxt;
    end
  end

  always_ff @(posedge clk or negedge RSTn) begin
    if (!RSTn) begin
      SRAM_CEn  <= 1'b1;
      SRAM_OEn  <= 1'b1;
      SRAM_WEn  <= 1'b1;
      SRAM_ADDR <= '0;
      SRAM_DATA <= '0;
    end else begin
      SRAM_CEn <= 1'b1;
      SRAM_OEn <= 1'b1;
      SRAM_WEn <= 1'b1;
      if (state == CLEAR) begin
        SRAM_CEn  <= 1'b0;
        SRAM_WEn  <= 1'b0;
        SRAM_ADDR <= cnt;
        SRAM_DATA <= CLR_VAL;
      end else if (gnt) begin
        SRAM_CEn  <= 1'b0;
        SRAM_ADDR <= sel_addr;
        if (sel_we) begin
          SRAM_WEn  <= 1'b0;
          SRAM_DATA <= sel_din;
        end else begin
          SRAM_OEn <= 1'b0;
        end
      end
    end
  end

  // read tags age two stages to line up with the SRAM's registered Q
  always_ff @(posedge clk or negedge RSTn) begin
    if (!RSTn) begin
      tag_v <= '0;
      tag_b <= '0;
    end else begin
      tag_v <= {tag_v[0], rd_issue};
      tag_b <= {tag_b[0], gnt_b};
    end
  end

  assign busy    = (state == CLEAR);
  assign ackA    = gnt_a;
  assign ackB    = gnt_b;
  assign rvalidA = tag_v[1] && !tag_b[1];
  assign rvalidB = tag_v[1] && tag_b[1];
  assign rdata   = SRAM_Q;

endmodule

// File: tb/tb_sram_share_ctrl.sv
// Random and directed bench for sram_share_ctrl with a behavioural
// SRAM, a spec-level reference model and a read-return scoreboard.
module tb_sram_share_ctrl;

  localparam int DW = 8;
  localparam int AW = 4;
  localparam int DEPTH = 16;
  localparam logic [7:0] FILL = 8'hA5;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rstn, clr, busy;
  logic reqA, reqB, weA, weB, ackA, ackB;
  logic [AW-1:0] addrA, addrB;
  logic [DW-1:0] dinA, dinB;
  logic rvalidA, rvalidB;
  logic [DW-1:0] rdata, sram_data, sram_q;
  logic [AW-1:0] sram_addr;
  logic ce_n, oe_n, we_n;

  sram_share_ctrl #(
    .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .RR(1'b1),
    .CLR_ON_RESET(1'b1), .CLR_VAL(FILL)
  ) u_rr (
    .clk(clk), .RSTn(rstn), .clr(clr), .busy(busy),
    .reqA(reqA), .reqB(reqB), .weA(weA), .weB(weB),
    .addrA(addrA), .addrB(addrB), .dinA(dinA), .dinB(dinB),
    .ackA(ackA), .ackB(ackB),
    .rvalidA(rvalidA), .rvalidB(rvalidB), .rdata(rdata),
    .SRAM_ADDR(sram_addr), .SRAM_DATA(sram_data),
    .SRAM_CEn(ce_n), .SRAM_OEn(oe_n), .SRAM_WEn(we_n),
    .SRAM_Q(sram_q)
  );

  // fixed-priority instance, driven by a short directed sequence
  logic fp_rstn, fp_reqA, fp_reqB, fp_busy;
  logic fp_ackA, fp_ackB, fp_rvA, fp_rvB;
  logic fp_ce, fp_oe, fp_we;
  logic [DW-1:0] fp_rdata, fp_sdata;
  logic [DW-1:0] fp_q = '0;
  logic [AW-1:0] fp_saddr;
  logic [AW-1:0] fp_addrA = 4'd1;
  logic [AW-1:0] fp_addrB = 4'd2;
  logic [DW-1:0] fp_din = '0;
  logic fp_clr = 1'b0;
  logic fp_we_in = 1'b0;

  sram_share_ctrl #(
    .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .RR(1'b0),
    .CLR_ON_RESET(1'b1), .CLR_VAL(FILL)
  ) u_fp (
    .clk(clk), .RSTn(fp_rstn), .clr(fp_clr), .busy(fp_busy),
    .reqA(fp_reqA), .reqB(fp_reqB),
    .weA(fp_we_in), .weB(fp_we_in),
    .addrA(fp_addrA), .addrB(fp_addrB),
    .dinA(fp_din), .dinB(fp_din),
    .ackA(fp_ackA), .ackB(fp_ackB),
    .rvalidA(fp_rvA), .rvalidB(fp_rvB), .rdata(fp_rdata),
    .SRAM_ADDR(fp_saddr), .SRAM_DATA(fp_sdata),
    .SRAM_CEn(fp_ce), .SRAM_OEn(fp_oe), .SRAM_WEn(fp_we),
    .SRAM_Q(fp_q)
  );

  // behavioural SRAM with registered Q
  logic [DW-1:0] sram_mem [DEPTH];
  always @(posedge clk) begin
    if (!ce_n) begin
      if (!we_n) sram_mem[sram_addr] <= sram_data;
      else if (!oe_n) sram_q <= sram_mem[sram_addr];
    end
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int total = 0;
  int bad = 0;

  task automatic chk(string nm, int act, int exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s at cycle %0d: got %0h want %0h",
               nm, cyc, act, exp);
    end
  endtask

  typedef struct {
    int due;
    bit own_b;
    logic [DW-1:0] data;
  } exp_t;
  exp_t exp_q[$];

  // reference model: fill countdown, last-grant owner, memory image
  int fill_left = DEPTH;
  bit last_a = 1'b0;
  logic [DW-1:0] mem_ref [DEPTH];
  bit p_ce = 1, p_oe = 1, p_we = 1;
  logic [AW-1:0] p_addr = '0;
  logic [DW-1:0] p_data = '0;

  initial forever begin
    bit ea, eb, w;
    logic [AW-1:0] ad;
    logic [DW-1:0] d;
    @(negedge clk);
    if (!rstn) begin
      chk("rst_ctl", {ce_n, oe_n, we_n}, 3'b111);
      chk("rst_addr", sram_addr, 0);
      chk("rst_data", sram_data, 0);
      chk("rst_busy", busy, 1);
      chk("rst_ack", {ackA, ackB}, 0);
      chk("rst_rvalid", {rvalidA, rvalidB}, 0);
      fill_left = DEPTH;
      last_a = 1'b0;
      exp_q.delete();
      p_ce = 1; p_oe = 1; p_we = 1;
      p_addr = '0; p_data = '0;
    end else begin
      chk("pin_ctl", {ce_n, oe_n, we_n}, {p_ce, p_oe, p_we});
      chk("pin_addr", sram_addr, p_addr);
      chk("pin_data", sram_data, p_data);
      chk("busy", busy, fill_left > 0);
      ea = 0; eb = 0;
      if (fill_left == 0 && !clr) begin
        ea = reqA && (!reqB || !last_a);
        eb = reqB && !ea;
      end
      chk("ack", {ackA, ackB}, {ea, eb});
      p_ce = 1; p_oe = 1; p_we = 1;
      if (fill_left > 0) begin
        ad = AW'(DEPTH - fill_left);
        p_ce = 0; p_we = 0;
        p_addr = ad; p_data = FILL;
        mem_ref[ad] = FILL;
        fill_left--;
      end else if (clr) begin
        fill_left = DEPTH;
      end else if (ea || eb) begin
        ad = ea ? addrA : addrB;
        d  = ea ? dinA : dinB;
        w  = ea ? weA : weB;
        p_ce = 0; p_addr = ad;
        if (w) begin
          p_we = 0; p_data = d;
          mem_ref[ad] = d;
        end else begin
          p_oe = 0;
          exp_q.push_back('{cyc + 2, eb, mem_ref[ad]});
        end
        last_a = ea;
      end
    end
  end

  // read-return monitor
  initial forever begin
    exp_t e;
    @(negedge clk);
    if (rstn) begin
      if (rvalidA || rvalidB) begin
        chk("rvalid_onehot", rvalidA && rvalidB, 0);
        if (exp_q.size() == 0) begin
          chk("rvalid_unexpected", 1, 0);
        end else begin
          e = exp_q.pop_front();
          chk("rd_cycle", cyc, e.due);
          chk("rd_owner", rvalidB, e.own_b);
          chk("rd_data", rdata, e.data);
        end
      end else if (exp_q.size() > 0 && exp_q[0].due <= cyc) begin
        e = exp_q.pop_front();
        chk("rvalid_missing", 0, 1);
      end
    end
  end

  bit accA, accB;

  task automatic step();
    @(negedge clk);
    accA = reqA && ackA;
    accB = reqB && ackB;
    @(posedge clk);
    #1;
  endtask

  function automatic logic [AW-1:0] pick_addr();
    if ($urandom_range(0, 1) == 1)
      return AW'($urandom_range(0, 3));
    return AW'($urandom_range(0, DEPTH - 1));
  endfunction

  task automatic rand_cycles(int n, int clr_rate);
    for (int i = 0; i < n; i++) begin
      step();
      if (!reqA || accA) begin
        reqA  = $urandom_range(0, 9) < 7;
        weA   = 1'($urandom_range(0, 1));
        addrA = pick_addr();
        dinA  = DW'($urandom);
      end
      if (!reqB || accB) begin
        reqB  = $urandom_range(0, 9) < 7;
        weB   = 1'($urandom_range(0, 1));
        addrB = pick_addr();
        dinB  = DW'($urandom);
      end
      clr = clr_rate > 0 &&
            $urandom_range(0, clr_rate - 1) == 0;
    end
  endtask

  task automatic do_a(bit w, logic [AW-1:0] ad, logic [DW-1:0] d);
    bit ok;
    reqA = 1; weA = w; addrA = ad; dinA = d;
    reqB = 0; clr = 0;
    ok = 0;
    for (int k = 0; k < 40 && !ok; k++) begin
      step();
      ok = accA;
    end
    reqA = 0;
    if (!ok) chk("accept_timeout", 0, 1);
  endtask

  initial begin
    rstn = 0; clr = 0;
    reqA = 1; weA = 0; addrA = '0; dinA = '0;
    reqB = 0; weB = 0; addrB = '0; dinB = '0;
    fp_rstn = 0; fp_reqA = 0; fp_reqB = 0;
    repeat (3) @(posedge clk);
    #1 rstn = 1;
    // reqA held through the boot fill
    repeat (18) step();
    reqA = 0;
    rand_cycles(300, 0);
    do_a(1, 4'd5, 8'h3C);
    do_a(0, 4'd5, 8'h00);
    repeat (4) step();
    // read in flight, then clr together with reqB
    do_a(0, 4'd2, 8'h00);
    clr = 1; reqB = 1; weB = 0; addrB = 4'd3;
    step();
    clr = 0; reqB = 0;
    repeat (20) step();
    rand_cycles(300, 30);
    // reset with a read tag in flight
    clr = 0;
    do_a(0, 4'd1, 8'h00);
    rstn = 0;
    repeat (2) step();
    rstn = 1;
    repeat (3) step();
    // reset again three cycles into the fill
    rstn = 0;
    repeat (2) step();
    rstn = 1;
    rand_cycles(150, 0);
    reqA = 0; reqB = 0; clr = 0;
    repeat (4) step();
    // fixed priority: B starves until A drops
    fp_reqA = 1; fp_reqB = 1;
    @(posedge clk);
    #1 fp_rstn = 1;
    repeat (DEPTH) begin
      @(negedge clk);
      chk("fp_fill_ack", {fp_ackA, fp_ackB}, 2'b00);
    end
    repeat (4) begin
      @(negedge clk);
      chk("fp_busy", fp_busy, 0);
      chk("fp_prio_ack", {fp_ackA, fp_ackB}, 2'b10);
    end
    @(posedge clk);
    #1 fp_reqA = 0;
    @(negedge clk);
    chk("fp_b_after_a", {fp_ackA, fp_ackB}, 2'b01);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
